// File: rtl/matmul_ctrl_param_pkg.sv
// Shared types and defaults for the parametrised matrix-multiply controller.
// Holds the FSM state encoding, default parameter values and sizing helpers.
package matmul_ctrl_param_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_DATA_W      = 18;
  localparam int DEF_N_LANES     = 4;
  localparam int DEF_N_GROUPS    = 4;
  localparam int DEF_N_COLS      = 16;
  localparam int DEF_LOAD_CYCLES = 2;
  localparam int DEF_RAM_AW      = 4;

  function automatic int tile_words(input int n_lanes, input int n_groups);
    return n_lanes * n_groups;
  endfunction

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmul_tile_buf.sv
// Tile buffer: one slot per result group, read back one word at a time.
// Read order is group-major by default, lane-major with TRANSPOSE_WRITE_EN.
module matmul_tile_buf
  import matmul_ctrl_param_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int N_LANES  = DEF_N_LANES,
  parameter int N_GROUPS = DEF_N_GROUPS,
  parameter int IDX_W    = DEF_RAM_AW,
  parameter int GRP_W    = cnt_w(DEF_N_GROUPS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [GRP_W-1:0]            wr_slot,
  input  logic [N_LANES*DATA_W-1:0]   wr_data,
  input  logic                        rd_en,
  input  logic [IDX_W-1:0]            rd_idx,
  output logic [DATA_W-1:0]           rd_data
);

  localparam int VEC_W = N_LANES * DATA_W;

  logic [VEC_W-1:0]  mem   [N_GROUPS];
  logic [VEC_W-1:0]  mem_n [N_GROUPS];
  logic [DATA_W-1:0] rd_word;

  function automatic int word_index(input int g, input int l);
`ifdef TRANSPOSE_WRITE_EN
    return l * N_GROUPS + g;
`else
    return g * N_LANES + l;
`endif
  endfunction

  // Reads see the slot being written this cycle, so the first word can leave
  // on the same edge that captures the final group.
  always_comb begin
    mem_n = mem;
    if (wr_en) mem_n[wr_slot] = wr_data;
  end

  always_comb begin
    rd_word = '0;
    for (int g = 0; g < N_GROUPS; g++) begin
      for (int l = 0; l < N_LANES; l++) begin
        if (rd_idx == IDX_W'(word_index(g, l)))
          rd_word = mem_n[g][(N_LANES-1-l)*DATA_W +: DATA_W];
      end
    end
  end

  // NOTE: this buffer is cleared by reset because its contents are observable
  // state; plain storage arrays normally stay out of the reset tree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int g = 0; g < N_GROUPS; g++) mem[g] <= '0;
      rd_data <= '0;
    end else begin
      mem     <= mem_n;
      rd_data <= rd_en ? rd_word : '0;
    end
  end

endmodule

// File: rtl/matmul_ctrl_param.sv
// Matrix-multiply controller: sequences LOAD, captures N_GROUPS result strobes,
// drains the tile to RAM and pulses finish. Build option: TRANSPOSE_WRITE_EN.
module matmul_ctrl_param
  import matmul_ctrl_param_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int N_LANES     = DEF_N_LANES,
  parameter int N_GROUPS    = DEF_N_GROUPS,
  parameter int N_COLS      = DEF_N_COLS,
  parameter int LOAD_CYCLES = DEF_LOAD_CYCLES,
  parameter int RAM_AW      = DEF_RAM_AW
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        arith_valid,
  input  logic [N_LANES*DATA_W-1:0]   results,
  output logic                        input_start,
  output logic                        rom_start,
  output logic [$clog2(N_COLS)-1:0]   rom_addr,
  output logic [DATA_W-1:0]           result,
  output logic [RAM_AW-1:0]           ram_addr,
  output logic                        web,
  output logic                        finish,
  output logic                        busy,
  output logic                        overrun
);

  localparam int WORDS = tile_words(N_LANES, N_GROUPS);
  localparam int COL_W = $clog2(N_COLS);
  localparam int GRP_W = cnt_w(N_GROUPS);
  localparam int LDC_W = cnt_w(LOAD_CYCLES);

  if ((2 ** RAM_AW) < WORDS) begin : g_bad_ram_aw
    $error("RAM_AW too small to address N_LANES*N_GROUPS words");
  end

  state_e             state, state_n;
  logic [COL_W-1:0]   col_cnt, col_n;
  logic [LDC_W-1:0]   ld_cnt, ld_n;
  logic [GRP_W-1:0]   grp_cnt, grp_n;
  logic [RAM_AW-1:0]  word_cnt, word_n;
  logic               overrun_n;
  logic               buf_wr;
  logic               load_q;

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n   = state;
    col_n     = col_cnt;
    ld_n      = ld_cnt;
    grp_n     = grp_cnt;
    word_n    = word_cnt;
    overrun_n = overrun;
    buf_wr    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n   = LOAD;
          overrun_n = 1'b0;
          col_n     = '0;
          ld_n      = '0;
          grp_n     = '0;
          word_n    = '0;
        end else if (arith_valid) begin
          overrun_n = 1'b1;
        end
      end
      LOAD: begin
        if (ld_cnt == LDC_W'(LOAD_CYCLES - 1)) begin
          ld_n  = '0;
          col_n = (col_cnt == COL_W'(N_COLS - 1)) ? '0 : col_cnt + COL_W'(1);
        end else begin
          ld_n = ld_cnt + LDC_W'(1);
        end
        if (arith_valid) begin
          buf_wr = 1'b1;
          if (grp_cnt == GRP_W'(N_GROUPS - 1)) begin
            // Counters park at zero so rom_addr/ram_addr read 0 outside their phase.
            state_n = WRITE;
            grp_n   = '0;
            col_n   = '0;
            ld_n    = '0;
            word_n  = '0;
          end else begin
            grp_n = grp_cnt + GRP_W'(1);
          end
        end
      end
      WRITE: begin
        if (arith_valid) overrun_n = 1'b1;
        if (word_cnt == RAM_AW'(WORDS - 1)) begin
          state_n = DONE;
          word_n  = '0;
        end else begin
          word_n = word_cnt + RAM_AW'(1);
        end
      end
      DONE: begin
        if (arith_valid) overrun_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      col_cnt  <= '0;
      ld_cnt   <= '0;
      grp_cnt  <= '0;
      word_cnt <= '0;
      overrun  <= 1'b0;
      load_q   <= 1'b0;
      web      <= 1'b0;
      finish   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      col_cnt  <= col_n;
      ld_cnt   <= ld_n;
      grp_cnt  <= grp_n;
      word_cnt <= word_n;
      overrun  <= overrun_n;
      load_q   <= (state_n == LOAD);
      web      <= (state_n == WRITE);
      finish   <= (state_n == DONE);
      busy     <= (state_n != IDLE);
    end
  end

  assign input_start = load_q;
  assign rom_start   = load_q;
  assign rom_addr    = col_cnt;
  assign ram_addr    = word_cnt;

  matmul_tile_buf #(
    .DATA_W   (DATA_W),
    .N_LANES  (N_LANES),
    .N_GROUPS (N_GROUPS),
    .IDX_W    (RAM_AW),
    .GRP_W    (GRP_W)
  ) u_tile_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (buf_wr),
    .wr_slot (grp_cnt),
    .wr_data (results),
    .rd_en   (state_n == WRITE),
    .rd_idx  (word_n),
    .rd_data (result)
  );

endmodule
